// File: rtl/usys_ctrl_pkg.sv
// Shared types and constants for the unary systolic GEMM array control.
// Used by the PE array and the edge stream controller.
package usys_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } usys_state_t;

  localparam logic [1:0] M_END_IDLE  = 2'b00;
  localparam logic [1:0] M_END_ACC   = 2'b01;
  localparam logic [1:0] M_END_DRAIN = 2'b10;

  // Primitive Fibonacci feedback masks, bit i = tap on state bit i
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] t;
    case (w)
      3:       t = 16'h0006;
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/usys_rand_gen.sv
// Random-number source: bit-reversed weight sample and ramp/LFSR input
// sample, registered and advanced on step.
import usys_ctrl_pkg::*;

module usys_rand_gen #(
  parameter int RAND_W   = 7,
  parameter int USE_LFSR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              step,
  input  logic [RAND_W-1:0] idx,
  output logic [RAND_W-1:0] w_rand,
  output logic [RAND_W-1:0] i_rand
);

  localparam logic [15:0] TAP_ALL = lfsr_taps(RAND_W);
  localparam logic [RAND_W-1:0] TAPS = TAP_ALL[RAND_W-1:0];
  localparam logic [RAND_W-1:0] SEED = RAND_W'(1);
  localparam bit ILFSR = (USE_LFSR != 0);

  logic [RAND_W-1:0] lfsr;
  logic [RAND_W-1:0] lfsr_nxt;
  logic [RAND_W-1:0] idx_rev;

  always_comb begin
    idx_rev = '0;
    for (int b = 0; b < RAND_W; b++) begin
      idx_rev[b] = idx[RAND_W-1-b];
    end
  end

  assign lfsr_nxt = {lfsr[RAND_W-2:0], ^(lfsr & TAPS)};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      lfsr   <= SEED;
      w_rand <= '0;
      i_rand <= '0;
    end else if (step) begin
      w_rand <= idx_rev;
      i_rand <= ILFSR ? lfsr : idx;
      lfsr   <= lfsr_nxt;
    end
  end

endmodule

// File: rtl/unary_stream_ctrl.sv
// Edge-column sequencer for the unary systolic GEMM array: tile FSM,
// stream/drain counters and registered PE control strobes.
import usys_ctrl_pkg::*;

module unary_stream_ctrl #(
  parameter int RAND_W       = 7,
  parameter int M_END_W      = 2,
  parameter int DRAIN_CYCLES = 8,
  parameter int USE_LFSR     = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [RAND_W-1:0]  b_w_rand_num,
  output logic [RAND_W-1:0]  b_i_rand_num,
  output logic               weight_reg_en,
  output logic               weight_reg_r0w1,
  output logic               input_reg_en,
  output logic               input_reg_r0w1,
  output logic               rand_num_reg_en,
  output logic               rand_num_reg_r0w1,
  output logic               output_num_reg_en,
  output logic               output_num_reg_r0w1,
  output logic [M_END_W-1:0] M_end
);

  localparam logic [7:0] D_LAST = 8'(DRAIN_CYCLES - 1);

  usys_state_t state;
  usys_state_t state_nxt;

  logic [RAND_W-1:0]  k;
  logic [RAND_W-1:0]  k_nxt;
  logic [7:0]         d_cnt;
  logic [7:0]         d_nxt;
  logic               step;
  logic               clr;
  logic [RAND_W-1:0]  idx;

  logic               ready_d;
  logic               busy_d;
  logic               done_d;
  logic               w_en_d;
  logic               i_en_d;
  logic               r_en_d;
  logic               o_en_d;
  logic [M_END_W-1:0] m_d;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    d_nxt     = d_cnt;
    step      = 1'b0;
    clr       = 1'b0;
    idx       = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          step      = 1'b1;
        end
      end
      LOAD: begin
        state_nxt = STREAM;
        k_nxt     = '0;
        step      = 1'b1;
        idx       = RAND_W'(1);
      end
      STREAM: begin
        k_nxt = k + RAND_W'(1);
        if (k == '1) begin
          state_nxt = DRAIN;
          d_nxt     = '0;
        end else begin
          step = 1'b1;
          idx  = k + RAND_W'(2);
        end
      end
      DRAIN: begin
        d_nxt = d_cnt + 8'd1;
        if (d_cnt == D_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Abort only matters while a tile is in flight
    if (abort && (state inside {LOAD, STREAM, DRAIN})) begin
      state_nxt = IDLE;
      k_nxt     = '0;
      d_nxt     = '0;
      step      = 1'b0;
      clr       = 1'b1;
    end
  end

  always_comb begin
    ready_d = (state_nxt == IDLE);
    busy_d  = (state_nxt inside {LOAD, STREAM, DRAIN});
    done_d  = (state_nxt == DONE);
    w_en_d  = (state_nxt == LOAD);
    i_en_d  = (state_nxt == STREAM);
    r_en_d  = (state_nxt inside {LOAD, STREAM});
    o_en_d  = (state_nxt inside {STREAM, DRAIN});
    m_d     = M_END_W'(M_END_IDLE);
    if (state_nxt == STREAM) begin
      m_d = M_END_W'(M_END_ACC);
    end else if (state_nxt == DRAIN) begin
      m_d = M_END_W'(M_END_DRAIN);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      k                   <= '0;
      d_cnt               <= '0;
      ready               <= 1'b1;
      busy                <= 1'b0;
      done                <= 1'b0;
      weight_reg_en       <= 1'b0;
      weight_reg_r0w1     <= 1'b0;
      input_reg_en        <= 1'b0;
      input_reg_r0w1      <= 1'b0;
      rand_num_reg_en     <= 1'b0;
      rand_num_reg_r0w1   <= 1'b0;
      output_num_reg_en   <= 1'b0;
      output_num_reg_r0w1 <= 1'b0;
      M_end               <= '0;
    end else begin
      state               <= state_nxt;
      k                   <= k_nxt;
      d_cnt               <= d_nxt;
      ready               <= ready_d;
      busy                <= busy_d;
      done                <= done_d;
      weight_reg_en       <= w_en_d;
      weight_reg_r0w1     <= w_en_d;
      input_reg_en        <= i_en_d;
      input_reg_r0w1      <= i_en_d;
      rand_num_reg_en     <= r_en_d;
      rand_num_reg_r0w1   <= r_en_d;
      output_num_reg_en   <= o_en_d;
      output_num_reg_r0w1 <= o_en_d;
      M_end               <= m_d;
    end
  end

  usys_rand_gen #(
    .RAND_W   (RAND_W),
    .USE_LFSR (USE_LFSR)
  ) u_rand (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .step   (step),
    .idx    (idx),
    .w_rand (b_w_rand_num),
    .i_rand (b_i_rand_num)
  );

endmodule

// File: tb/tb_unary_stream_ctrl.sv
// Directed bench for unary_stream_ctrl: ramp instance (RAND_W=3) and
// LFSR instance (RAND_W=4), sharing clock and control inputs.
module tb_unary_stream_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, abort;

  logic       ready_a, busy_a, done_a;
  logic [2:0] w_a, i_a;
  logic       wen_a, wr_a, ien_a, ir_a, ren_a, rr_a, oen_a, or_a;
  logic [1:0] m_a;

  logic       ready_b, busy_b, done_b;
  logic [3:0] w_b, i_b;
  logic       wen_b, wr_b, ien_b, ir_b, ren_b, rr_b, oen_b, or_b;
  logic [1:0] m_b;

  unary_stream_ctrl #(
    .RAND_W(3), .M_END_W(2), .DRAIN_CYCLES(2), .USE_LFSR(0)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ready(ready_a), .busy(busy_a), .done(done_a),
    .b_w_rand_num(w_a), .b_i_rand_num(i_a),
    .weight_reg_en(wen_a), .weight_reg_r0w1(wr_a),
    .input_reg_en(ien_a), .input_reg_r0w1(ir_a),
    .rand_num_reg_en(ren_a), .rand_num_reg_r0w1(rr_a),
    .output_num_reg_en(oen_a), .output_num_reg_r0w1(or_a),
    .M_end(m_a)
  );

  unary_stream_ctrl #(
    .RAND_W(4), .M_END_W(2), .DRAIN_CYCLES(3), .USE_LFSR(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ready(ready_b), .busy(busy_b), .done(done_b),
    .b_w_rand_num(w_b), .b_i_rand_num(i_b),
    .weight_reg_en(wen_b), .weight_reg_r0w1(wr_b),
    .input_reg_en(ien_b), .input_reg_r0w1(ir_b),
    .rand_num_reg_en(ren_b), .rand_num_reg_r0w1(rr_b),
    .output_num_reg_en(oen_b), .output_num_reg_r0w1(or_b),
    .M_end(m_b)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       st, ab;
    logic       rdy, bsy, dn;
    logic [1:0] m;
    logic       we, ie, re, oe;
    logic [2:0] w, i;
  } vec_t;

  vec_t tv[14];

  // PE_edge model: weight abs 5, input abs 3, both sign 0
  logic [2:0] pe_w, pe_i;
  int         psum;
  always @(posedge clk) begin
    if (reset) begin
      pe_w <= '0;
      pe_i <= '0;
      psum <= 0;
    end else begin
      if (ren_a) begin
        pe_w <= w_a;
        pe_i <= i_a;
      end
      if (wen_a) psum <= 0;
      else if (m_a == 2'b01 && (3'd5 > pe_w) && (3'd3 > pe_i))
        psum <= psum + 1;
    end
  end

  function automatic vec_t mk(
    input logic st, ab, rdy, bsy, dn,
    input logic [1:0] m,
    input logic we, ie, re, oe,
    input logic [2:0] w, i
  );
    vec_t v;
    v.st = st; v.ab = ab; v.rdy = rdy; v.bsy = bsy; v.dn = dn;
    v.m = m; v.we = we; v.ie = ie; v.re = re; v.oe = oe;
    v.w = w; v.i = i;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [14:0] pk_a();
    return {ready_a, busy_a, done_a, m_a, wen_a, ien_a, ren_a, oen_a,
            w_a, i_a};
  endfunction

  function automatic logic [16:0] pk_b();
    return {ready_b, busy_b, done_b, m_b, wen_b, ien_b, ren_b, oen_b,
            w_b, i_b};
  endfunction

  logic [2:0] wseq [8];
  logic [3:0] smp [17];
  logic [15:0] seen;
  logic        bad, dn_seen;
  int          cyc, bcnt;

  initial begin
    wseq = '{3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7, 3'd0};
    tv[0] = mk(1, 1, 0, 1, 0, 2'b00, 1, 0, 1, 0, 3'd0, 3'd0);
    for (int r = 1; r <= 8; r++)
      tv[r] = mk(r == 4, 0, 0, 1, 0, 2'b01, 0, 1, 1, 1,
                 wseq[r-1], 3'(r));
    tv[9]  = mk(0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 1, 3'd0, 3'd0);
    tv[10] = mk(0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 1, 3'd0, 3'd0);
    tv[11] = mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 3'd0, 3'd0);
    tv[12] = mk(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 3'd0, 3'd0);
    tv[13] = mk(0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 3'd0, 3'd0);

    // Reset then idle
    do_reset();
    chk("reset_a", 32'(pk_a()), 32'h4000);
    chk("reset_b", 32'(pk_b()), 32'h10000);
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (pk_a() !== 15'h4000 || pk_b() !== 17'h10000) bad = 1'b1;
      if ({wr_a, ir_a, rr_a, or_a, wr_b, ir_b, rr_b, or_b} !== 8'h00)
        bad = 1'b1;
    end
    chk("idle_hold", 32'(bad), 32'h0);

    // Full tile on ramp instance, table driven
    for (int r = 0; r < 14; r++) begin
      start = tv[r].st;
      abort = tv[r].ab;
      tick();
      chk($sformatf("tile_row%0d", r), 32'(pk_a()),
          32'({tv[r].rdy, tv[r].bsy, tv[r].dn, tv[r].m, tv[r].we,
               tv[r].ie, tv[r].re, tv[r].oe, tv[r].w, tv[r].i}));
      chk($sformatf("r0w1_row%0d", r), 32'({wr_a, ir_a, rr_a, or_a}),
          32'({tv[r].we, tv[r].ie, tv[r].re, tv[r].oe}));
    end
    start = 1'b0;
    abort = 1'b0;

    // Abort mid-STREAM at k=3
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("k3_w", 32'({m_a, w_a}), 32'({2'b01, 3'd1}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(pk_a() & 15'h7FC0), 32'h4000);
    dn_seen = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (done_a) dn_seen = 1'b1;
    end
    chk("abort_no_done", 32'(dn_seen), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("replay_w0", 32'({wen_a, w_a}), 32'({1'b1, 3'd0}));
    tick();
    chk("replay_w1", 32'(w_a), 32'd4);
    tick();
    chk("replay_w2", 32'(w_a), 32'd2);

    // LFSR instance
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    smp[0] = i_b;
    for (int n = 1; n < 17; n++) begin
      tick();
      smp[n] = i_b;
    end
    chk("lfsr_seed", 32'(smp[0]), 32'h1);
    seen = '0;
    for (int n = 0; n < 15; n++) seen[smp[n]] = 1'b1;
    chk("lfsr_cover", 32'(seen), 32'hFFFE);
    chk("lfsr_period", 32'(smp[15]), 32'(smp[0]));
    tick();
    chk("drain_hold", 32'({m_b, oen_b, ren_b, i_b}),
        32'({2'b10, 1'b1, 1'b0, smp[16]}));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_drain", 32'(pk_b()), 32'h10000);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lfsr_reseed", 32'({wen_b, i_b}), 32'({1'b1, 4'd1}));
    cyc = 1;
    bcnt = 1;
    while (!done_b && cyc < 100) begin
      tick();
      cyc++;
      if (busy_b) bcnt++;
    end
    chk("b_start_to_done", 32'(cyc), 32'd21);
    chk("b_busy_len", 32'(bcnt), 32'd20);

    // PE_edge partial sum
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 13; c++) tick();
    chk("pe_psum", 32'(psum), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
